ifetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the decode/execute stage of the single-cycle CPU.
- Owns the fetch PC and drives a synchronous-read instruction ROM with one-cycle latency.
- Buffers returned words in a small FIFO and presents them with valid/ready to the decoder.
- Supports redirect/flush so later branch and jump logic can steer fetch.

---
 rtl/ifetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end with PC, 1-cycle ROM interface and
// a small return FIFO presented to decode with valid/ready.
// Optional feature macro: IFQ_HALT_EN (stop fetching after HALT_PC, report halted).
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] HALT_PC  = 32'h0040_000c
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     ins_valid,
    output logic [31:0]              ins,
    output logic [31:0]              ins_pc,
    input  logic                     ins_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ifetch_queue: DEPTH must be a power of two >= 2");
    end
    if (HALT_PC[1:0] != 2'b00) begin : g_bad_halt_pc
        $error("ifetch_queue: HALT_PC must be word aligned");
    end

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_pc;
    logic             r_inflight;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_ins [DEPTH];
    logic [31:0]      r_mem_pc  [DEPTH];

    logic             w_stop;
    logic             w_room;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] w_occ;

    // Capacity: queued words plus the one in flight must leave a free slot
    assign w_occ   = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_room  = w_occ < OCC_W'(DEPTH);
    assign w_issue = !rst && !redirect_valid && w_room && !w_stop;
    assign w_push  = r_inflight;
    assign w_pop   = (r_count != '0) && ins_ready;

    assign rom_en    = w_issue;
    assign rom_addr  = r_fetch_pc[ADDR_W+1:2];
    assign ins_valid = (r_count != '0);
    assign ins       = ins_valid ? r_mem_ins[r_rd_ptr] : 32'h0;
    assign ins_pc    = ins_valid ? r_mem_pc[r_rd_ptr]  : 32'h0;
    assign count     = r_count;

    // Fetch PC, in-flight tracking, FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 32'h0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ~32'h3;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the returning ROM word with its fetch address
    always_ff @(posedge clk) begin
        if (w_push && !rst && !redirect_valid) begin
            r_mem_ins[r_wr_ptr] <= rom_data;
            r_mem_pc[r_wr_ptr]  <= r_req_pc;
        end
    end

`ifdef IFQ_HALT_EN
    logic r_stop;

    // Latch stop once the HALT_PC word has been issued; redirect restarts fetch
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_stop <= 1'b0;
        end else if (w_issue && (r_fetch_pc == HALT_PC)) begin
            r_stop <= 1'b1;
        end
    end

    assign w_stop = r_stop;
    assign halted = r_stop && (r_count == '0) && !r_inflight;
`else
    assign w_stop = 1'b0;
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed plus randomized checks of ifetch_queue against a
// stream-level model (sequential PCs, redirect restarts, ROM word = A000_0000 + word index).
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic [2:0]  count;
    logic        halted;

    int total = 0;
    int bad   = 0;

    ifetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .count          (count),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle latency; word k holds A000_0000 + k
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'hA000_0000 + 32'(rom_addr);
    end

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'hA000_0000 + 32'(pc[7:2]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_ins;
        logic        prev_hold;
        logic        found;
        logic        saw_next;
        logic        halted_seen;
        logic        redir;
        int          delivered;

        rst = 1'b1; ins_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        cyc(); cyc(); #1;
        chk("rst_rom_en", rom_en === 1'b0);
        chk("rst_valid", ins_valid === 1'b0);
        chk("rst_count", count === 3'd0);
        chk("rst_ins", ins === 32'h0);
        chk("rst_ins_pc", ins_pc === 32'h0);
        chk("rst_halted", halted === 1'b0);

        // First issue right after reset release, valid two cycles later
        cyc(); rst = 1'b0; #1;
        chk("first_issue", rom_en === 1'b1);
        chk("first_addr", rom_addr === 6'd0);
        ins_ready = 1'b1;
        cyc(); #1;
        chk("lat_valid1", ins_valid === 1'b0);
        chk("lat_addr1", rom_addr === 6'd1);
        cyc(); #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            #1;
            chk("stream_valid", ins_valid === 1'b1);
            chk("stream_pc", ins_pc === 32'h0040_0000 + 32'(4 * k));
            chk("stream_ins", ins === 32'hA000_0000 + 32'(k));
        end

        // Reset mid-stream discards everything and restarts at RESET_PC
        cyc(); rst = 1'b1; ins_ready = 1'b0; #1;
        chk("mid_rst_rom_en", rom_en === 1'b0);
        cyc(); rst = 1'b0; #1;
        chk("mid_rst_count", count === 3'd0);
        chk("mid_rst_valid", ins_valid === 1'b0);
        chk("mid_rst_ins", ins === 32'h0);
        chk("mid_rst_pc", ins_pc === 32'h0);
        chk("mid_rst_halted", halted === 1'b0);
        chk("mid_rst_addr", rom_addr === 6'd0);
        chk("mid_rst_issue", rom_en === 1'b1);

        // Decoder stalled: queue fills to DEPTH and fetch stops
        repeat (10) cyc();
        #1;
        chk("full_count", count === 3'd4);
        chk("full_rom_en", rom_en === 1'b0);
        chk("full_valid", ins_valid === 1'b1);
        chk("full_head_ins", ins === 32'hA000_0000);
        chk("full_head_pc", ins_pc === 32'h0040_0000);

        // Drain in order with no gaps or duplicates
        ins_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            #1;
            chk("drain_valid", ins_valid === 1'b1);
            chk("drain_pc", ins_pc === 32'h0040_0000 + 32'(4 * k));
            chk("drain_ins", ins === 32'hA000_0000 + 32'(k));
        end

        // Redirect to an unaligned address while three words are queued
        ins_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            if (count == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_three", found === 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0023; #1;
        chk("redir_no_issue", rom_en === 1'b0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("redir_valid", ins_valid === 1'b0);
        chk("redir_count", count === 3'd0);
        chk("redir_issue", rom_en === 1'b1);
        chk("redir_addr", rom_addr === 6'd8);
        ins_ready = 1'b1;
        cyc(); #1;
        chk("redir_lat", ins_valid === 1'b0);
        cyc(); #1;
        chk("redir_first_valid", ins_valid === 1'b1);
        chk("redir_first_pc", ins_pc === 32'h0040_0020);
        chk("redir_first_ins", ins === 32'hA000_0008);

        // Redirect coinciding with pop and ROM return
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0048; #1;
        chk("redir2_busy", ins_valid === 1'b1);
        cyc(); redirect_valid = 1'b0; #1;
        chk("redir2_count", count === 3'd0);
        chk("redir2_valid", ins_valid === 1'b0);
        chk("redir2_addr", rom_addr === 6'd18);
        cyc(); #1;
        chk("redir2_lat", ins_valid === 1'b0);
        cyc(); #1;
        chk("redir2_pc", ins_pc === 32'h0040_0048);
        chk("redir2_ins", ins === 32'hA000_0012);

        // End-of-program behaviour, build dependent
        rst = 1'b1; ins_ready = 1'b1;
        cyc(); rst = 1'b0;
        exp_pc = 32'h0040_0000; delivered = 0; saw_next = 1'b0; halted_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc(); #1;
            if (rom_en && rom_addr == 6'd4) saw_next = 1'b1;
            if (halted) halted_seen = 1'b1;
            if (ins_valid) begin
                chk("halt_order", ins_pc === exp_pc);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
`ifdef IFQ_HALT_EN
        chk("halt_delivered", delivered === 4);
        chk("halt_flag", halted === 1'b1);
        chk("halt_rom_en", rom_en === 1'b0);
        chk("halt_no_next", saw_next === 1'b0);
`else
        chk("free_delivered", delivered === 13);
        chk("free_next_fetched", saw_next === 1'b1);
        chk("free_never_halted", halted_seen === 1'b0);
`endif

        // Randomized ready/redirect traffic against the stream model
        rst = 1'b1; redirect_valid = 1'b0;
        cyc(); rst = 1'b0;
        exp_pc = 32'h0040_0000; prev_hold = 1'b0; prev_pc = 32'h0; prev_ins = 32'h0; delivered = 0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            ins_ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            redirect_valid = redir;
            redirect_pc = 32'h0040_0000 | 32'($urandom_range(0, 255));
            #1;
            if (prev_hold) begin
                chk("rnd_hold_valid", ins_valid === 1'b1);
                chk("rnd_hold_pc", ins_pc === prev_pc);
                chk("rnd_hold_ins", ins === prev_ins);
            end
            chk("rnd_count_bound", count <= 3'd4);
            if (redir) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (ins_valid && ins_ready) begin
                chk("rnd_pc", ins_pc === exp_pc);
                chk("rnd_ins", ins === exp_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_hold = !redir && ins_valid && !ins_ready;
            prev_pc   = ins_pc;
            prev_ins  = ins;
        end
        chk("rnd_progress", delivered > 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
